// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle RV32I main control unit: opcodes,
// FSM states, instruction classes, datapath select codes and fault codes.
package control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Per-state datapath controls. The FETCH ir_write/pc_write pulse depends on
  // memory ready and is added outside this table.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_SRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRC_A_OLD_PC;
        c.alu_src_b = SRC_B_IMM;
      end
      S_EXEC_R: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_RS2;
        c.alu_op    = ALU_RFUNCT;
      end
      S_EXEC_I: begin
        c.alu_src_b = SRC_B_IMM;
        c.alu_op    = ALU_IFUNCT;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        c.i_or_d    = 1'b1;
        c.mem_write = 1'b1;
      end
      S_WB_ALU: c.reg_write = 1'b1;
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRC_A_RS1;
        c.alu_src_b     = SRC_B_RS2;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_SRC_ALU_OUT;
      end
      // rd receives old PC + 4 while the PC takes the jump target.
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_SRC_JUMP;
        c.reg_write = 1'b1;
        c.alu_src_a = SRC_A_OLD_PC;
        c.alu_src_b = SRC_B_FOUR;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction opcode and memory ready in,
// datapath enables/selects and fault report out.
interface multicycle_control_if;
  logic [6:0] op_code;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    input  op_code, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           fault, fault_code
  );

  modport slave (
    output op_code, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           fault, fault_code
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode -> instruction class map; JAL is illegal when not supported.
module opcode_class_decode
  import control_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic [6:0]   op_code,
  output instr_class_t op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op_code)
      OP_R:      op_class = CLS_R;
      OP_I:      op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = SUPPORT_JAL ? CLS_JAL : CLS_ILLEGAL;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control FSM: 3-5 cycles per instruction plus one per stall
// cycle; memory accesses hold on mem_ready low and fault after MAX_WAIT stalls.
module multicycle_control
  import control_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned MAX_WAIT    = 15,
  parameter bit          SUPPORT_JAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master ctl
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  // Counter value on the last tolerated stall cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t             state;
  state_t             nxt;
  ctrl_t              ctrl_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               is_store_q;
  logic               fault_q;
  logic [1:0]         fault_code_q;
  instr_class_t       op_class;
  logic               ready_eff;
  logic               mem_state;
  logic               timeout;
  logic               fetch_go;

  opcode_class_decode #(.SUPPORT_JAL(SUPPORT_JAL)) u_decode (
    .op_code  (ctl.op_code),
    .op_class (op_class)
  );

  assign ready_eff = MEM_WAIT_EN ? ctl.mem_ready : 1'b1;
  assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Ready has priority: a completing access on the last allowed cycle is not a timeout.
  assign timeout   = mem_state && !ready_eff && (wait_cnt == CNT_LAST);
  assign fetch_go  = (state == S_FETCH) && ready_eff;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = ready_eff ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
      S_DECODE: begin
        case (op_class)
          CLS_R:                nxt = S_EXEC_R;
          CLS_I:                nxt = S_EXEC_I;
          CLS_LOAD, CLS_STORE:  nxt = S_MEM_ADDR;
          CLS_BRANCH:           nxt = S_BRANCH;
          CLS_JAL:              nxt = S_JAL;
          default:              nxt = S_FAULT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
      S_MEM_ADDR: nxt = is_store_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = ready_eff ? S_WB_MEM : (timeout ? S_FAULT : S_MEM_RD);
      S_MEM_WR:   nxt = ready_eff ? S_FETCH : (timeout ? S_FAULT : S_MEM_WR);
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: nxt = S_FETCH;
      S_FAULT:    nxt = S_FAULT;
      default:    nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ctrl_q       <= '0;
      wait_cnt     <= '0;
      is_store_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt);
      if (nxt != state) begin
        wait_cnt <= '0;
      end else if (mem_state && !ready_eff) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (state == S_DECODE) begin
        is_store_q <= (op_class == CLS_STORE);
      end
      // Only DECODE can fault on opcode; every other fault entry is a stall timeout.
      if (nxt == S_FAULT && state != S_FAULT) begin
        fault_q      <= 1'b1;
        fault_code_q <= (state == S_DECODE) ? FAULT_ILLEGAL : FAULT_TIMEOUT;
      end
    end
  end

  assign ctl.pc_write      = ctrl_q.pc_write | fetch_go;
  assign ctl.pc_write_cond = ctrl_q.pc_write_cond;
  assign ctl.ir_write      = fetch_go;
  assign ctl.i_or_d        = ctrl_q.i_or_d;
  assign ctl.mem_read      = ctrl_q.mem_read;
  assign ctl.mem_write     = ctrl_q.mem_write;
  assign ctl.mem_to_reg    = ctrl_q.mem_to_reg;
  assign ctl.reg_write     = ctrl_q.reg_write;
  assign ctl.alu_src_a     = ctrl_q.alu_src_a;
  assign ctl.alu_src_b     = ctrl_q.alu_src_b;
  assign ctl.alu_op        = ctrl_q.alu_op;
  assign ctl.pc_source     = ctrl_q.pc_source;
  assign ctl.fault         = fault_q;
  assign ctl.fault_code    = fault_code_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle output vectors predicted from the
// instruction class, stall counts and reset/fault rules.
module tb_multicycle_control;

  logic clk;
  logic rst_a;
  logic rst_b;

  multicycle_control_if ifa ();
  multicycle_control_if ifb ();

  multicycle_control dut_a (
    .clk   (clk),
    .rst_n (rst_a),
    .ctl   (ifa.master)
  );

  multicycle_control #(.MEM_WAIT_EN(1'b0), .MAX_WAIT(15), .SUPPORT_JAL(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_b),
    .ctl   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
  //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, fault, fault_code}
  localparam logic [18:0] V_IDLE       = 19'b0;
  localparam logic [18:0] V_FETCH_WAIT = {8'b0000_1000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] V_FETCH_GO   = {8'b1010_1000, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] V_DECODE     = {8'b0000_0000, 2'b10, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] V_EXEC_R     = {8'b0000_0000, 2'b01, 2'b00, 2'b10, 2'b00, 3'b000};
  localparam logic [18:0] V_EXEC_I     = {8'b0000_0000, 2'b00, 2'b10, 2'b11, 2'b00, 3'b000};
  localparam logic [18:0] V_MEM_ADDR   = {8'b0000_0000, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [18:0] V_MEM_RD     = {8'b0001_1000, 8'b0, 3'b000};
  localparam logic [18:0] V_MEM_WR     = {8'b0001_0100, 8'b0, 3'b000};
  localparam logic [18:0] V_WB_ALU     = {8'b0000_0001, 8'b0, 3'b000};
  localparam logic [18:0] V_WB_MEM     = {8'b0000_0011, 8'b0, 3'b000};
  localparam logic [18:0] V_BRANCH     = {8'b0100_0000, 2'b01, 2'b00, 2'b01, 2'b01, 3'b000};
  localparam logic [18:0] V_JAL        = {8'b1000_0001, 2'b10, 2'b01, 2'b00, 2'b10, 3'b000};
  localparam logic [18:0] V_FAULT_ILL  = {16'b0, 3'b101};
  localparam logic [18:0] V_FAULT_TO   = {16'b0, 3'b110};

  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4, C_JAL = 5;

  logic [18:0] obs_a;
  logic [18:0] obs_b;
  logic [18:0] obs;
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  assign obs_a = {ifa.pc_write, ifa.pc_write_cond, ifa.ir_write, ifa.i_or_d, ifa.mem_read,
                  ifa.mem_write, ifa.mem_to_reg, ifa.reg_write, ifa.alu_src_a, ifa.alu_src_b,
                  ifa.alu_op, ifa.pc_source, ifa.fault, ifa.fault_code};
  assign obs_b = {ifb.pc_write, ifb.pc_write_cond, ifb.ir_write, ifb.i_or_d, ifb.mem_read,
                  ifb.mem_write, ifb.mem_to_reg, ifb.reg_write, ifb.alu_src_a, ifb.alu_src_b,
                  ifb.alu_op, ifb.pc_source, ifb.fault, ifb.fault_code};

  function automatic logic [6:0] op_of(int cls);
    case (cls)
      C_R:      return 7'b0110011;
      C_I:      return 7'b0010011;
      C_LOAD:   return 7'b0000011;
      C_STORE:  return 7'b0100011;
      C_BRANCH: return 7'b1100011;
      default:  return 7'b1101111;
    endcase
  endfunction

  // One clock cycle: apply inputs, check outputs mid-cycle, advance past the edge.
  task automatic run_cycle(input bit which, input logic rdy, input logic [6:0] op,
                           input logic [18:0] exp, input string tag);
    if (!which) begin
      ifa.mem_ready = rdy;
      ifa.op_code   = op;
    end else begin
      ifb.mem_ready = rdy;
      ifb.op_code   = op;
    end
    @(negedge clk);
    obs = which ? obs_b : obs_a;
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%05h expected=%05h", tag, cyc, obs, exp);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rnd_cycle(input logic [18:0] exp, input string tag);
    run_cycle(1'b0, 1'($urandom), 7'($urandom), exp, tag);
  endtask

  // Full instruction on dut_a from FETCH entry; sf/sm = stall cycles on fetch / data access.
  task automatic run_instr(input int cls, input int sf, input int sm);
    for (int i = 0; i < sf; i++) run_cycle(1'b0, 1'b0, 7'($urandom), V_FETCH_WAIT, "fetch_wait");
    run_cycle(1'b0, 1'b1, 7'($urandom), V_FETCH_GO, "fetch_go");
    run_cycle(1'b0, 1'($urandom), op_of(cls), V_DECODE, "decode");
    case (cls)
      C_R: begin
        rnd_cycle(V_EXEC_R, "exec_r");
        rnd_cycle(V_WB_ALU, "wb_alu_r");
      end
      C_I: begin
        rnd_cycle(V_EXEC_I, "exec_i");
        rnd_cycle(V_WB_ALU, "wb_alu_i");
      end
      C_LOAD: begin
        rnd_cycle(V_MEM_ADDR, "mem_addr_ld");
        for (int i = 0; i < sm; i++) run_cycle(1'b0, 1'b0, 7'($urandom), V_MEM_RD, "mem_rd_wait");
        run_cycle(1'b0, 1'b1, 7'($urandom), V_MEM_RD, "mem_rd_done");
        rnd_cycle(V_WB_MEM, "wb_mem");
      end
      C_STORE: begin
        rnd_cycle(V_MEM_ADDR, "mem_addr_st");
        for (int i = 0; i < sm; i++) run_cycle(1'b0, 1'b0, 7'($urandom), V_MEM_WR, "mem_wr_wait");
        run_cycle(1'b0, 1'b1, 7'($urandom), V_MEM_WR, "mem_wr_done");
      end
      C_BRANCH: rnd_cycle(V_BRANCH, "branch");
      default:  rnd_cycle(V_JAL, "jal");
    endcase
  endtask

  // Assert reset during a cycle whose outputs are exp_now; leaves dut_a about to enter FETCH.
  task automatic reset_a(input logic rdy, input logic [18:0] exp_now);
    rst_a = 1'b0;
    run_cycle(1'b0, rdy, 7'($urandom), exp_now, "pre_reset");
    rnd_cycle(V_IDLE, "reset_idle");
    rst_a = 1'b1;
    rnd_cycle(V_IDLE, "idle_after_reset");
  endtask

  initial begin
    int cls, sf, sm;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ifa.mem_ready = 1'b0;
    ifa.op_code   = 7'd0;
    ifb.mem_ready = 1'b0;
    ifb.op_code   = 7'd0;
    @(posedge clk);
    #1;
    rnd_cycle(V_IDLE, "reset_state");
    rst_a = 1'b1;
    rnd_cycle(V_IDLE, "idle");

    // Directed flows: zero-wait R, stalled load, store, branch, JAL, I.
    run_instr(C_R, 0, 0);
    run_instr(C_LOAD, 0, 3);
    run_instr(C_STORE, 0, 0);
    run_instr(C_BRANCH, 0, 0);
    run_instr(C_JAL, 0, 0);
    run_instr(C_I, 1, 0);

    for (int n = 0; n < 40; n++) begin
      cls = $urandom_range(0, 5);
      sf  = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      sm  = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3);
      run_instr(cls, sf, sm);
    end

    // Ready arriving on the last allowed stall cycle completes normally.
    run_instr(C_R, 14, 0);
    run_instr(C_LOAD, 0, 14);
    run_instr(C_STORE, 14, 14);

    // Fetch timeout: 15 stalled cycles then sticky timeout fault.
    for (int i = 0; i < 15; i++) run_cycle(1'b0, 1'b0, 7'($urandom), V_FETCH_WAIT, "to_fetch_wait");
    for (int i = 0; i < 5; i++) rnd_cycle(V_FAULT_TO, "timeout_fault");
    reset_a(1'b0, V_FAULT_TO);

    // Data-read timeout.
    run_cycle(1'b0, 1'b1, 7'd0, V_FETCH_GO, "fetch_go_rdto");
    run_cycle(1'b0, 1'b0, op_of(C_LOAD), V_DECODE, "decode_rdto");
    rnd_cycle(V_MEM_ADDR, "mem_addr_rdto");
    for (int i = 0; i < 15; i++) run_cycle(1'b0, 1'b0, 7'($urandom), V_MEM_RD, "rdto_wait");
    for (int i = 0; i < 3; i++) rnd_cycle(V_FAULT_TO, "rdto_fault");
    reset_a(1'b1, V_FAULT_TO);

    // Illegal opcode: fault held for 20 cycles regardless of inputs.
    run_cycle(1'b0, 1'b1, 7'd0, V_FETCH_GO, "fetch_go_ill");
    run_cycle(1'b0, 1'b1, 7'b1111111, V_DECODE, "decode_ill");
    for (int i = 0; i < 20; i++) rnd_cycle(V_FAULT_ILL, "illegal_fault");
    reset_a(1'b1, V_FAULT_ILL);

    // Reset in the middle of a stalled store.
    run_cycle(1'b0, 1'b1, 7'd0, V_FETCH_GO, "fetch_go_rst");
    run_cycle(1'b0, 1'b0, op_of(C_STORE), V_DECODE, "decode_rst");
    rnd_cycle(V_MEM_ADDR, "mem_addr_rst");
    run_cycle(1'b0, 1'b0, 7'd0, V_MEM_WR, "mem_wr_stall1");
    run_cycle(1'b0, 1'b0, 7'd0, V_MEM_WR, "mem_wr_stall2");
    reset_a(1'b0, V_MEM_WR);
    run_instr(C_R, 0, 0);

    // Second instance: ready ignored, JAL illegal. dut_a parked in reset.
    rst_a = 1'b0;
    rst_b = 1'b1;
    run_cycle(1'b1, 1'b0, 7'd0, V_IDLE, "b_idle");
    run_cycle(1'b1, 1'b0, 7'd0, V_FETCH_GO, "b_fetch_noready");
    run_cycle(1'b1, 1'b0, op_of(C_LOAD), V_DECODE, "b_decode_ld");
    run_cycle(1'b1, 1'b0, 7'd0, V_MEM_ADDR, "b_mem_addr");
    run_cycle(1'b1, 1'b0, 7'd0, V_MEM_RD, "b_mem_rd_noready");
    run_cycle(1'b1, 1'b0, 7'd0, V_WB_MEM, "b_wb_mem");
    run_cycle(1'b1, 1'b0, 7'd0, V_FETCH_GO, "b_fetch2");
    run_cycle(1'b1, 1'b0, op_of(C_JAL), V_DECODE, "b_decode_jal");
    for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'($urandom), 7'($urandom), V_FAULT_ILL, "b_jal_illegal");
    n_cmp++;
    assert (obs_a === V_IDLE) else begin
      n_err++;
      $error("FAIL a_parked observed=%05h expected=%05h", obs_a, V_IDLE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle main control unit for the RV32I datapath. It succeeds the single-cycle opcode decoder. It steps each instruction through a registered state machine (fetch, decode, execute, memory, write-back) and drives the datapath muxes, register-file and memory enables, and ALU operation class. It adds a memory ready/stall handshake, a bounded wait timeout, optional JAL support, and a sticky fault report.

## Interface
- `MEM_WAIT_EN`, 1: 1 = honour `mem_ready`; 0 = memory treated as always ready.
- `MAX_WAIT`, 15: maximum stall cycles per memory access before fault; counter width `$clog2(MAX_WAIT+1)`.
- `SUPPORT_JAL`, 1: 1 = decode JAL (1101111); 0 = JAL is an illegal opcode.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `op_code` input 7: `instr[6:0]` from the instruction register; sampled only in DECODE.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_write` output 1 each: datapath enables and selects.
- `alu_src_a` output 2: 00 PC, 01 rs1, 10 old PC.
- `alu_src_b` output 2: 00 rs2, 01 const 4, 10 immediate.
- `alu_op` output 2: 00 add, 01 sub/compare, 10 R-type funct decode, 11 I-type funct decode.
- `pc_source` output 2: 00 ALU result, 01 ALU out register, 10 jump target.
- `fault` output 1: sticky error flag.
- `fault_code` output 2: 00 none, 01 illegal opcode, 10 memory timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JAL, FAULT.
- IDLE → FETCH unconditionally.
- FETCH: `mem_read=1`, `i_or_d=0`, `alu_src_a=00`, `alu_src_b=01`, `alu_op=00`, `pc_source=00`. While ready is low, hold FETCH. When ready: pulse `ir_write`/`pc_write`, go to DECODE.
- DECODE: `alu_src_a=10`, `alu_src_b=10`, `alu_op=00` (branch target precompute). Dispatch on `op_code`:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 / 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL (if `SUPPORT_JAL`)
  - otherwise → FAULT, code 01
- EXEC_R: `alu_src_a=01`, `alu_src_b=00`, `alu_op=10` → WB_ALU.
- EXEC_I: `alu_src_b=10`, `alu_op=11` → WB_ALU.
- MEM_ADDR: `alu_src_a=01`, `alu_src_b=10`, `alu_op=00` → MEM_RD for a load, MEM_WR for a store. The opcode class is latched in DECODE.
- MEM_RD: `mem_read=1`, `i_or_d=1`. Hold until ready, then → WB_MEM.
- MEM_WR: `mem_write=1`, `i_or_d=1`. Hold until ready, then → FETCH.
- WB_ALU: `reg_write=1`, `mem_to_reg=0` → FETCH.
- WB_MEM: `reg_write=1`, `mem_to_reg=1` → FETCH.
- BRANCH: `alu_src_a=01`, `alu_src_b=00`, `alu_op=01`, `pc_write_cond=1`, `pc_source=01` → FETCH.
- JAL: `pc_write=1`, `pc_source=10`, `reg_write=1`, `mem_to_reg=0`, `alu_src_a=10`, `alu_src_b=01` (rd = old PC + 4) → FETCH.
- FAULT: all enables 0. `fault=1`, `fault_code` held. Only reset exits.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states with `mem_ready=0`.
  - When it reaches `MAX_WAIT` with ready still low → FAULT, code 10.
  - Ready and counter reaching `MAX_WAIT` in the same cycle: ready wins, access completes.
- `MEM_WAIT_EN=0`: ready forced to 1 internally; counter logic may be optimised away, and timeout is unreachable.
- Unlisted outputs are 0 in every state.

## Timing
- Outputs are decoded from the registered state. Exception: `ir_write`/`pc_write` in FETCH are also gated by the effective ready.
- State, counter and fault registers update on rising `clk`.
- Reset (any cycle, including mid-stall or in FAULT): next state IDLE, counter 0, `fault=0`, `fault_code=00`, all outputs 0.
- Zero-wait latency (cycles from FETCH entry to the next FETCH entry):
  - R/I: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
- Each stall cycle adds 1 cycle.
- `op_code` need only be stable in DECODE.

## Structure
- `control_pkg`:
  - opcode constants
  - state enum
  - `alu_op`, `alu_src_a`, `alu_src_b` and `pc_source` encodings
  - fault code constants
- Sub-module `opcode_class_decode`: combinational; maps `op_code` plus `SUPPORT_JAL` to an instruction class (R, I, LOAD, STORE, BRANCH, JAL, ILLEGAL). The FSM and counter live in `multicycle_control`.

## Test plan
- Reset, zero wait, `op_code=0110011`:
  - States IDLE, FETCH, DECODE, EXEC_R, WB_ALU, FETCH.
  - `reg_write=1`, `mem_to_reg=0` only in WB_ALU.
  - `alu_op=10` in EXEC_R.
- `op_code=0000011`, `mem_ready` low for 3 cycles in MEM_RD:
  - MEM_RD held 4 cycles with `mem_read=1`, `i_or_d=1`.
  - WB_MEM follows with `reg_write=1`, `mem_to_reg=1`.
  - Total 8 cycles FETCH to FETCH.
- `op_code=0100011` then `1100011`:
  - `mem_write=1` exactly 1 cycle.
  - `pc_write_cond=1`, `alu_op=01` in BRANCH.
  - 4 and 3 cycles respectively.
- Fault paths:
  - `op_code=1111111` → `fault=1`, `fault_code=01` from the cycle after DECODE, held for 20 cycles.
  - `SUPPORT_JAL=0` with `op_code=1101111` → same result.
- `MAX_WAIT=15`, `mem_ready` held low in FETCH → FAULT with `fault_code=10` after 15 stall cycles.
- Timeout race: `mem_ready=1` on the 15th stall cycle → normal DECODE, no fault.
- `rst_n=0` asserted mid-stall in MEM_WR → next cycle IDLE, `mem_write=0`, `fault=0`.
